// File: rtl/bz_pkg.sv
// Shared constants and types for the BZ serializer/deserializer pair.
package bz_pkg;

   typedef enum logic {
      IDLE,
      SEND
   } bz_state_t;

   function automatic int bz_nflit(int npccode, int npcdata, int nbd);
      return (npccode + npcdata + nbd - 1) / nbd;
   endfunction

   function automatic int bz_npad(int npccode, int npcdata, int nbd);
      return bz_nflit(npccode, npcdata, nbd) * nbd - (npccode + npcdata);
   endfunction

   function automatic int bz_tail_idx(int nbd);
      return nbd;
   endfunction

endpackage

// File: rtl/bz_channel.sv
// Valid/ready word channel between the PC decoder and the serializer.
interface Channel #(
   parameter int N = 32
) ();
   logic         v;
   logic [N-1:0] d;
   logic         a;

   modport sink   (input v, input d, output a);
   modport source (output v, output d, input a);
endinterface

// File: rtl/bz_serializer.sv
// Splits one PC word into tail-marked flits for the router DC FIFO.
module bz_serializer
   import bz_pkg::*;
#(
   parameter int NPCcode = 8,
   parameter int NPCdata = 24,
   parameter int NBDdata = 10
) (
   input  logic             clk,
   input  logic             reset,
   Channel.sink             PC_in,
   output logic [NBDdata:0] data,
   output logic             wrreq,
   input  logic             wrfull
);

   localparam int NFLIT = bz_nflit(NPCcode, NPCdata, NBDdata);
   localparam int NIMG  = NFLIT * NBDdata;
   localparam int TAIL  = bz_tail_idx(NBDdata);
   localparam int CW    = (NFLIT > 1) ? $clog2(NFLIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(NFLIT - 1);

   bz_state_t       state;
   logic [CW-1:0]   cnt;
   logic [NIMG-1:0] sr;
   logic [NIMG-1:0] img;
   logic            last;
   logic            wr;

   // Pad bits land on top, so the first flit carries them.
   assign img   = NIMG'(PC_in.d);
   assign last  = (state == SEND) && (cnt == LAST);
   assign wr    = (state == SEND) && !wrfull;
   assign wrreq = wr;
   assign PC_in.a = reset &&
                    ((state == IDLE) || (last && !wrfull));

   assign data[TAIL]           = last;
   assign data[NBDdata-1:0]    = sr[NIMG-1 -: NBDdata];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         sr    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (PC_in.v) begin
                  sr    <= img;
                  cnt   <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (wr) begin
                  if (cnt != LAST) begin
                     sr  <= sr << NBDdata;
                     cnt <= cnt + CW'(1);
                  end else if (PC_in.v) begin
                     sr  <= img;
                     cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bz_serializer.sv
// Randomized scoreboard bench for bz_serializer.
module tb_bz_serializer;

   logic        clk;
   logic        reset;
   logic [10:0] data;
   logic        wrreq;
   logic        wrfull;
   logic        rand_full;

   int vectors;
   int miscompares;

   logic [10:0] q[$];

   Channel #(.N(32)) ch ();

   bz_serializer #(
      .NPCcode(8),
      .NPCdata(24),
      .NBDdata(10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .PC_in (ch),
      .data  (data),
      .wrreq (wrreq),
      .wrfull(wrfull)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  n, act, exp, $time);
      end
   endtask

   // Reference: 40-bit image, four 10-bit slices MS first.
   task automatic push_word(input logic [31:0] d);
      logic [39:0] im;
      logic [10:0] f;
      im = {8'h00, d};
      for (int k = 0; k < 4; k++) begin
         f[9:0] = 10'((im >> (10 * (3 - k))) & 40'h3FF);
         f[10]  = (k == 3);
         q.push_back(f);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         logic ea;
         ea = (q.size() == 0) || (q.size() == 1 && !wrfull);
         chk("ready", 32'(ch.a), 32'(ea));
         if (wrfull)
            chk("wrreq_while_full", 32'(wrreq), 0);
         else if (q.size() > 0)
            chk("no_bubble", 32'(wrreq), 1);
         if (wrfull && q.size() > 0)
            chk("stall_hold", 32'(data), 32'(q[0]));
         if (wrreq && !wrfull) begin
            if (q.size() == 0)
               chk("extra_write", 32'(data), 32'h7FF_FFFF);
            else
               chk("flit", 32'(data), 32'(q.pop_front()));
         end
         if (ch.v && ch.a)
            push_word(ch.d);
      end
   end

   always @(posedge clk) begin
      #2;
      if (rand_full)
         wrfull = ($urandom_range(0, 3) == 0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] d);
      int n;
      ch.v = 1'b1;
      ch.d = d;
      n = 0;
      forever begin
         @(negedge clk);
         if (ch.a) break;
         n++;
         if (n > 60) begin
            chk("accept_timeout", 0, 1);
            break;
         end
      end
      step();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 32'(q.size()), 0);
      step();
      step();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rand_full   = 1'b0;
      reset  = 1'b0;
      wrfull = 1'b0;
      ch.v   = 1'b0;
      ch.d   = '0;
      #1;
      chk("rst_wrreq", 32'(wrreq), 0);
      chk("rst_data", 32'(data), 0);
      chk("rst_a", 32'(ch.a), 0);
      repeat (2) step();
      reset = 1'b1;
      step();
      chk("idle_a", 32'(ch.a), 1);

      put(32'h12345678);
      ch.v = 1'b0;
      drain();
      chk("post_a", 32'(ch.a), 1);
      chk("post_wrreq", 32'(wrreq), 0);

      put(32'hFFFFFFFF);
      ch.v = 1'b0;
      drain();

      put(32'h12345678);
      put(32'hFFFFFFFF);
      ch.v = 1'b0;
      drain();

      put(32'h12345678);
      ch.v = 1'b0;
      step();
      wrfull = 1'b1;
      repeat (3) step();
      chk("stall_data", 32'(data), 32'h123);
      wrfull = 1'b0;
      drain();

      put(32'h12345678);
      ch.d = 32'hA5A5A5A5;
      repeat (2) step();
      wrfull = 1'b1;
      step();
      chk("last_stall_a", 32'(ch.a), 0);
      step();
      wrfull = 1'b0;
      put(32'hA5A5A5A5);
      ch.v = 1'b0;
      drain();

      put(32'h12345678);
      ch.v = 1'b0;
      repeat (2) step();
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_wrreq", 32'(wrreq), 0);
      chk("mid_rst_data", 32'(data), 0);
      chk("mid_rst_a", 32'(ch.a), 0);
      q.delete();
      step();
      reset = 1'b1;
      step();
      put(32'h0BADF00D);
      ch.v = 1'b0;
      drain();

      rand_full = 1'b1;
      for (int i = 0; i < 40; i++) begin
         put($urandom);
         if ($urandom_range(0, 2) == 0) begin
            ch.v = 1'b0;
            repeat ($urandom_range(1, 5)) step();
         end
      end
      ch.v = 1'b0;
      rand_full = 1'b0;
      wrfull = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck, expected finish");
      $fatal(1);
   end

endmodule
